// File: rtl/sprite_loader.sv
//----------------------------------------------------------------------------
// Module      : sprite_loader
// Description : Streams a WIDTH x HEIGHT bit sprite from a host byte stream
//               into serial sprite storage, LSB of each byte first. Bits
//               are only pushed while vblank is high, so the renderer is
//               never disturbed mid-frame.
// Ports       : clk, reset_n        - clock / async active-low reset
//               start, abort        - begin / cancel a load
//               vblank              - storage may be written this cycle
//               byte_data/valid     - host byte stream
//               byte_ready          - byte accepted this cycle
//               shiftf, load        - forward-shift strobe / serial select
//               data_out            - serial bit into storage
//               busy, done          - load in progress / completion pulse
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sprite_loader #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       vblank,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       shiftf,
  output logic       load,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam int NBITS = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BYTE = 2'd1,
    S_SHIFT     = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_byte;

  logic             w_in_shift;
  logic             w_strobe;

  assign w_in_shift = (r_state == S_SHIFT);
  // abort wins over vblank: the cycle that cancels a load must not move storage
  assign w_strobe   = w_in_shift && vblank && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_byte    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_WAIT_BYTE;
            r_bit_cnt <= '0;
            r_bit_idx <= 3'd0;
          end
        end
        S_WAIT_BYTE: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (byte_valid) begin
            r_byte  <= byte_data;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (vblank) begin
            r_byte    <= {1'b0, r_byte[7:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_bit_idx <= r_bit_idx + 3'd1;
            // The sprite may end part-way through a byte; remaining bits
            // of that byte are simply dropped.
            if (r_bit_cnt == C_LAST_BIT) begin
              r_state <= S_DONE;
            end else if (r_bit_idx == 3'd7) begin
              r_state <= S_WAIT_BYTE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state; the strobe follows vblank
  // in the same cycle so a vblank drop pauses the stream immediately.
  assign byte_ready = (r_state == S_WAIT_BYTE);
  assign shiftf     = w_strobe;
  assign load       = w_strobe;
  assign data_out   = w_in_shift && r_byte[0];
  assign busy       = (r_state == S_WAIT_BYTE) || w_in_shift;
  assign done       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sprite_loader.sv
//----------------------------------------------------------------------------
// Module      : tb_sprite_loader
// Description : Self-checking bench for sprite_loader (10x10 and 3x3).
//               Expected storage bit k is byte[k/8] bit (k%8); expected
//               strobe count is NBITS and accepted bytes ceil(NBITS/8).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_sprite_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       abort = 1'b0, vblank = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;

  logic a_ready, a_shiftf, a_load, a_data, a_busy, a_done;
  logic b_ready, b_shiftf, b_load, b_data, b_busy, b_done;

  always #5 clk = ~clk;

  sprite_loader u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
    .vblank(vblank), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(a_ready), .shiftf(a_shiftf), .load(a_load),
    .data_out(a_data), .busy(a_busy), .done(a_done)
  );

  sprite_loader #(.WIDTH(3), .HEIGHT(3)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
    .vblank(vblank), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(b_ready), .shiftf(b_shiftf), .load(b_load),
    .data_out(b_data), .busy(b_busy), .done(b_done)
  );

  // sel chooses which instance the monitor and driver talk to
  logic sel = 1'b0;
  wire m_ready  = sel ? b_ready  : a_ready;
  wire m_shiftf = sel ? b_shiftf : a_shiftf;
  wire m_load   = sel ? b_load   : a_load;
  wire m_data   = sel ? b_data   : a_data;
  wire m_busy   = sel ? b_busy   : a_busy;
  wire m_done   = sel ? b_done   : a_done;

  int   total = 0, bad = 0;
  int   stb_cnt = 0, acc_cnt = 0, done_cnt = 0, cyc = 0;
  int   last_stb_cyc = -1, done_cyc = -1;
  logic cap [0:127];
  logic [7:0] bytes [0:15];

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (m_shiftf) begin
      if (stb_cnt < 128) cap[stb_cnt] = m_data;
      stb_cnt++;
      last_stb_cyc = cyc;
    end
    if (m_ready && byte_valid && !abort) acc_cnt++;
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    total++;
    if ((m_load !== m_shiftf) || (m_shiftf && !vblank) || (m_shiftf && m_ready) ||
        (m_ready && m_data) || (!m_busy && (m_shiftf || m_data || m_ready)) ||
        (m_done && m_busy)) begin
      bad++;
      $display("FAIL invariant cyc=%0d got rdy=%b shf=%b ld=%b dat=%b busy=%b done=%b vblank=%b",
               cyc, m_ready, m_shiftf, m_load, m_data, m_busy, m_done, vblank);
    end
  end

  // Reference model: number of storage bits disagreeing with the byte stream
  function automatic int storage_errs(input int nbits);
    int e = 0;
    for (int k = 0; k < nbits; k++)
      if (cap[k] !== bytes[k / 8][k % 8]) e++;
    return e;
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic clear_counts();
    stb_cnt = 0; acc_cnt = 0; done_cnt = 0;
    last_stb_cyc = -1; done_cyc = -1;
    for (int k = 0; k < 128; k++) cap[k] = 1'bx;
  endtask

  // Drives one load: vmode 0=vblank high, 1=toggle every 3 cycles, 2=random.
  // delay: cycles byte_valid stays low after each accepted byte.
  // abort_at >= 0 aborts once that many strobes have been seen.
  task automatic run_load(input int vmode, input int delay, input int abort_at,
                          input bit restart_mid);
    int  wait_cnt = 0, last_acc = 0;
    bit  aborted = 0, finished = 0;
    clear_counts();
    @(posedge clk); #1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    for (int b = 0; b < 4000 && !finished; b++) begin
      if (acc_cnt != last_acc) begin
        last_acc = acc_cnt;
        wait_cnt = 0;
      end
      byte_data  = bytes[acc_cnt % 16];
      byte_valid = (wait_cnt >= delay);
      wait_cnt++;
      case (vmode)
        0:       vblank = 1'b1;
        1:       vblank = ((b / 3) % 2) == 0;
        default: vblank = 1'($urandom_range(0, 1));
      endcase
      abort = (abort_at >= 0) && (stb_cnt == abort_at);
      if (abort) aborted = 1;
      set_start(restart_mid && (b == 20));
      @(posedge clk); #1;
      abort = 1'b0;
      set_start(1'b0);
      if (done_cnt > 0 || aborted) finished = 1;
    end
    byte_valid = 1'b0;
    vblank     = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("FAIL load_timeout got strobes=%0d done=%0d want completion", stb_cnt, done_cnt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_ready, a_shiftf, a_load, a_data, a_busy, a_done,
         b_ready, b_shiftf, b_load, b_data, b_busy, b_done} !== 12'b0) begin
      bad++;
      $display("FAIL reset_hold got a=%b%b%b%b%b%b b=%b%b%b%b%b%b want all 0",
               a_ready, a_shiftf, a_load, a_data, a_busy, a_done,
               b_ready, b_shiftf, b_load, b_data, b_busy, b_done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    vblank = 1'b1; byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({a_ready, a_shiftf, a_busy, a_done, b_ready, b_shiftf, b_busy, b_done} !== 8'b0) begin
      bad++;
      $display("FAIL reset_release got a_busy=%b a_rdy=%b b_busy=%b b_rdy=%b want 0",
               a_busy, a_ready, b_busy, b_ready);
    end
    vblank = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int e;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
    bytes[0] = 8'hFC; bytes[1] = 8'h0B;
    run_load(0, 0, -1, 0);
    repeat (3) @(negedge clk);
    e = storage_errs(100);
    total++;
    if (stb_cnt !== 100) begin bad++; $display("FAIL full_strobes got %0d want 100", stb_cnt); end
    total++;
    if (acc_cnt !== 13) begin bad++; $display("FAIL full_bytes got %0d want 13", acc_cnt); end
    total++;
    if (cap[0] !== 1'b0 || cap[2] !== 1'b1) begin
      bad++; $display("FAIL full_bit0_bit2 got %b,%b want 0,1", cap[0], cap[2]);
    end
    total++;
    if (e != 0) begin bad++; $display("FAIL full_storage got %0d bad bits want 0", e); end
    total++;
    if (done_cnt !== 1 || done_cyc !== last_stb_cyc + 1) begin
      bad++; $display("FAIL full_done got count=%0d at=%0d want 1 at %0d",
                      done_cnt, done_cyc, last_stb_cyc + 1);
    end
    total++;
    if (a_busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got %b want 0", a_busy); end
  endtask

  task automatic test_vblank_toggle();
    int e;
    sel = 1'b0;
    run_load(1, 0, -1, 0);
    repeat (2) @(negedge clk);
    e = storage_errs(100);
    total++;
    if (stb_cnt !== 100 || done_cnt !== 1) begin
      bad++; $display("FAIL vbl_counts got strobes=%0d done=%0d want 100,1", stb_cnt, done_cnt);
    end
    total++;
    if (e != 0) begin bad++; $display("FAIL vbl_storage got %0d bad bits want 0", e); end
  endtask

  task automatic test_slow_bytes();
    int e;
    sel = 1'b0;
    run_load(0, 13, -1, 0);
    repeat (2) @(negedge clk);
    e = storage_errs(100);
    total++;
    if (stb_cnt !== 100 || acc_cnt !== 13 || done_cnt !== 1) begin
      bad++; $display("FAIL slow_counts got strobes=%0d bytes=%0d done=%0d want 100,13,1",
                      stb_cnt, acc_cnt, done_cnt);
    end
    total++;
    if (e != 0) begin bad++; $display("FAIL slow_storage got %0d bad bits want 0", e); end
  endtask

  task automatic test_abort();
    int e;
    sel = 1'b0;
    run_load(0, 0, 37, 0);
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", a_busy); end
    vblank = 1'b1; byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    vblank = 1'b0; byte_valid = 1'b0;
    total++;
    if (stb_cnt !== 37 || done_cnt !== 0) begin
      bad++; $display("FAIL abort_counts got strobes=%0d done=%0d want 37,0", stb_cnt, done_cnt);
    end
    run_load(2, 0, -1, 0);
    repeat (2) @(negedge clk);
    e = storage_errs(100);
    total++;
    if (stb_cnt !== 100 || done_cnt !== 1 || e != 0) begin
      bad++; $display("FAIL abort_reload got strobes=%0d done=%0d badbits=%0d want 100,1,0",
                      stb_cnt, done_cnt, e);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    sel = 1'b0;
    clear_counts();
    @(posedge clk); #1;
    set_start(1'b1); vblank = 1'b1; byte_valid = 1'b1; byte_data = bytes[0];
    @(posedge clk); #1;
    set_start(1'b0);
    for (int b = 0; b < 50 && stb_cnt < 5; b++) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({a_ready, a_shiftf, a_load, a_data, a_busy, a_done} !== 6'b0) begin
      bad++; $display("FAIL reset_mid_async got %b%b%b%b%b%b want 000000",
                      a_ready, a_shiftf, a_load, a_data, a_busy, a_done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0; byte_valid = 1'b0;
    total++;
    if (a_busy !== 1'b0 || done_cnt !== 0) begin
      bad++; $display("FAIL reset_mid_idle got busy=%b done=%0d want 0,0", a_busy, done_cnt);
    end
    // start pulsed mid-load must not restart the counters
    run_load(0, 0, -1, 1);
    repeat (2) @(negedge clk);
    e = storage_errs(100);
    total++;
    if (stb_cnt !== 100 || done_cnt !== 1 || e != 0) begin
      bad++; $display("FAIL start_busy got strobes=%0d done=%0d badbits=%0d want 100,1,0",
                      stb_cnt, done_cnt, e);
    end
  endtask

  task automatic test_start_abort();
    sel = 1'b0;
    @(posedge clk); #1;
    set_start(1'b1); abort = 1'b1;
    @(posedge clk); #1;
    set_start(1'b0); abort = 1'b0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b1 || a_ready !== 1'b1) begin
      bad++; $display("FAIL start_abort got busy=%b rdy=%b want 1,1", a_busy, a_ready);
    end
    @(posedge clk); #1;
    abort = 1'b1; byte_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0) begin bad++; $display("FAIL abort_wait got busy=%b want 0", a_busy); end
  endtask

  task automatic test_small();
    int e;
    sel = 1'b1;
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
    run_load(2, 0, -1, 0);
    repeat (3) @(negedge clk);
    e = storage_errs(9);
    total++;
    if (acc_cnt !== 2 || stb_cnt !== 9 || done_cnt !== 1) begin
      bad++; $display("FAIL small_counts got bytes=%0d strobes=%0d done=%0d want 2,9,1",
                      acc_cnt, stb_cnt, done_cnt);
    end
    total++;
    if (e != 0) begin bad++; $display("FAIL small_storage got %0d bad bits want 0", e); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int e, nb;
    for (int r = 0; r < 4; r++) begin
      sel = r[0];
      nb  = sel ? 9 : 100;
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      run_load(2, int'($urandom_range(0, 12)), -1, 0);
      repeat (2) @(negedge clk);
      e = storage_errs(nb);
      total++;
      if (stb_cnt !== nb || acc_cnt !== (nb + 7) / 8 || done_cnt !== 1 || e != 0) begin
        bad++; $display("FAIL random_%0d got strobes=%0d bytes=%0d done=%0d badbits=%0d want %0d,%0d,1,0",
                        r, stb_cnt, acc_cnt, done_cnt, e, nb, (nb + 7) / 8);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_full_load();
    test_vblank_toggle();
    test_slow_bytes();
    test_abort();
    test_reset_mid();
    test_start_abort();
    test_small();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
